channel_in_multi_times_acc: RTL and testbench

- Accumulates per-pixel partial sums across successive input-channel groups (passes) of one convolution tile.
- Sits directly downstream of the fixed 6-cycle channel_in_one_times_acc delay stage and consumes its output stream.
- Pass 0 seeds a buffer, middle passes add into it, and the last pass emits final sums toward the quantisation/output stage.
- No backpressure; the input stream is free-running like the upstream delay line.

---
 rtl/channel_in_multi_times_acc_pkg.sv | 18 +
 rtl/channel_in_multi_times_acc_ram.sv | 22 ++
 rtl/channel_in_multi_times_acc.sv | 165 ++++++++++++++++
 tb/tb_channel_in_multi_times_acc.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/channel_in_multi_times_acc_pkg.sv
// Shared constants for the multi-pass channel accumulator.
// The lane defaults come from the shared Para.v macros; the fallbacks below apply only when that header is absent.
`ifndef PICTURE_NUM
`define PICTURE_NUM 4
`endif
`ifndef WIDTH_DATA_OUT
`define WIDTH_DATA_OUT 8
`endif
`ifndef ACC_DEPTH
`define ACC_DEPTH 1024
`endif

package channel_in_multi_times_acc_pkg;
   localparam int ST_W = 2;
   localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
   localparam logic [ST_W-1:0] ST_RUN   = 2'd1;
   localparam logic [ST_W-1:0] ST_FLUSH = 2'd2;
endpackage

// File: rtl/channel_in_multi_times_acc_ram.sv
// Simple dual-port accumulation buffer with a 1-cycle registered read.
// A read and a write to the same address in the same cycle return the old contents.
module acc_buffer_ram #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 10
)(
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)    mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/channel_in_multi_times_acc.sv
// Accumulates per-pixel partial sums over the input-channel passes of one tile.
// Pass 0 seeds the buffer, middle passes add into it, and the last pass emits saturated sums.
module channel_in_multi_times_acc
   import channel_in_multi_times_acc_pkg::*;
#(
   parameter int LANES  = `PICTURE_NUM,
   parameter int LANE_W = 2*`WIDTH_DATA_OUT,
   parameter int DEPTH  = `ACC_DEPTH,
   parameter int ADDR_W = 10
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [15:0]             pixel_num,
   input  logic [7:0]              pass_num,
   input  logic                    valid_in,
   input  logic [LANES*LANE_W-1:0] data_in,
   output logic                    valid_out,
   output logic [LANES*LANE_W-1:0] data_out,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);
   localparam int DW = LANES*LANE_W;

   logic [ST_W-1:0]   state;
   logic [15:0]       pix_num_q;
   logic [7:0]        pass_num_q;
   logic [ADDR_W-1:0] pix_cnt;
   logic [7:0]        pass_cnt;
   logic              fl_cnt;

   logic accept, start_ok, pix_wrap, beat_first, beat_last;

   logic              s1_vld, s1_first, s1_last;
   logic [ADDR_W-1:0] s1_addr;
   logic [DW-1:0]     s1_data;
   logic              fwd_hit;
   logic [DW-1:0]     fwd_data;
   logic [DW-1:0]     rd_data, operand, sum;
   logic              ram_we;

   assign start_ok   = (pixel_num != 16'd0) && ({1'b0, pixel_num} <= 17'(DEPTH)) && (pass_num != 8'd0);
   assign accept     = (state == ST_RUN) && valid_in;
   assign pix_wrap   = (16'(pix_cnt) == pix_num_q - 16'd1);
   assign beat_first = (pass_cnt == 8'd0);
   assign beat_last  = (pass_cnt == pass_num_q - 8'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         pix_num_q  <= '0;
         pass_num_q <= '0;
         pix_cnt    <= '0;
         pass_cnt   <= '0;
         fl_cnt     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (start_ok) begin
                     pix_num_q  <= pixel_num;
                     pass_num_q <= pass_num;
                     pix_cnt    <= '0;
                     pass_cnt   <= '0;
                     busy       <= 1'b1;
                     state      <= ST_RUN;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (valid_in) begin
                  if (pix_wrap) begin
                     pix_cnt  <= '0;
                     pass_cnt <= pass_cnt + 8'd1;
                     if (beat_last) begin
                        fl_cnt <= 1'b0;
                        state  <= ST_FLUSH;
                     end
                  end else begin
                     pix_cnt <= pix_cnt + 1'b1;
                  end
               end
            end
            ST_FLUSH: begin
               // done lands in the same cycle as the last valid_out
               fl_cnt <= 1'b1;
               if (!fl_cnt) begin
                  done <= 1'b1;
               end else begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign ram_we = s1_vld && !s1_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld    <= 1'b0;
         s1_first  <= 1'b0;
         s1_last   <= 1'b0;
         s1_addr   <= '0;
         s1_data   <= '0;
         fwd_hit   <= 1'b0;
         fwd_data  <= '0;
         valid_out <= 1'b0;
         data_out  <= '0;
      end else begin
         s1_vld <= accept;
         if (accept) begin
            s1_data  <= data_in;
            s1_addr  <= pix_cnt;
            s1_first <= beat_first;
            s1_last  <= beat_last;
         end
         // RAM read sees pre-write data on a same-address collision, so keep the sum aside
         fwd_hit <= accept && ram_we && (s1_addr == pix_cnt);
         if (ram_we) fwd_data <= sum;
         valid_out <= s1_vld && s1_last;
         if (s1_vld && s1_last) data_out <= sum;
      end
   end

   assign operand = fwd_hit ? fwd_data : rd_data;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [LANE_W-1:0] a, b, lane_sum;
      logic [LANE_W:0]   wide;
      logic              ovf;
      assign a    = operand[l*LANE_W +: LANE_W];
      assign b    = s1_data[l*LANE_W +: LANE_W];
      assign wide = {a[LANE_W-1], a} + {b[LANE_W-1], b};
      assign ovf  = wide[LANE_W] ^ wide[LANE_W-1];
      assign lane_sum = s1_first ? b :
                        !ovf     ? wide[LANE_W-1:0] :
                        wide[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
      assign sum[l*LANE_W +: LANE_W] = lane_sum;
   end

   acc_buffer_ram #(
      .WIDTH (DW),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
   ) u_ram (
      .clk    (clk),
      .we     (ram_we),
      .wr_addr(s1_addr),
      .wr_data(sum),
      .rd_en  (accept),
      .rd_addr(pix_cnt),
      .rd_data(rd_data)
   );
endmodule

// File: tb/tb_channel_in_multi_times_acc.sv
// Directed bench: table of accumulation jobs plus hand-written error and abort sequences.
module tb_channel_in_multi_times_acc;
   localparam int LANES = 2, LANE_W = 16, DEPTH = 1024, ADDR_W = 10;
   localparam int DW = LANES*LANE_W;

   logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, valid_in = 1'b0;
   logic [15:0]   pixel_num = '0;
   logic [7:0]    pass_num = '0;
   logic [DW-1:0] data_in = '0;
   logic          valid_out, busy, done, err;
   logic [DW-1:0] data_out;

   int n_cmp = 0, n_err = 0;
   int cyc = 0;
   int out_cyc[$];
   logic [DW-1:0] out_dat[$];
   int done_cnt = 0, done_cyc = -1, err_cnt = 0, we_cnt = 0;

   typedef struct packed {
      int pix;
      int pas;
      bit gap;
      logic [3:0][15:0] v0, v1, e0, e1;
   } job_t;
   job_t jobs[8];

   channel_in_multi_times_acc #(.LANES(LANES), .LANE_W(LANE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pixel_num(pixel_num), .pass_num(pass_num),
      .valid_in(valid_in), .data_in(data_in), .valid_out(valid_out), .data_out(data_out),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid_out) begin
         out_cyc.push_back(cyc);
         out_dat.push_back(data_out);
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (err) err_cnt++;
      if (dut.ram_we) we_cnt++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [3:0][15:0] q4(input int a, input int b, input int c, input int d);
      logic [3:0][15:0] r;
      r[0] = 16'(a); r[1] = 16'(b); r[2] = 16'(c); r[3] = 16'(d);
      return r;
   endfunction

   function automatic logic [DW-1:0] pk(input logic [15:0] a, input logic [15:0] b);
      return {b, a};
   endfunction

   function automatic int s16(input logic [15:0] x);
      return int'($signed(x));
   endfunction

   task automatic run_job(input int j);
      job_t jb;
      int in_last[$];
      jb = jobs[j];
      out_cyc.delete(); out_dat.delete();
      done_cnt = 0; done_cyc = -1; we_cnt = 0;
      pixel_num = 16'(jb.pix); pass_num = 8'(jb.pas); start = 1'b1;
      step();
      start = 1'b0;
      chk($sformatf("job%0d_busy_rise", j), int'(busy), 1);
      for (int p = 0; p < jb.pas; p++) begin
         for (int k = 0; k < jb.pix; k++) begin
            valid_in = 1'b1;
            data_in  = pk(jb.v0[k], jb.v1[k]);
            if (p == jb.pas - 1) in_last.push_back(cyc);
            step();
            if (jb.gap) begin
               valid_in = 1'b0;
               step();
            end
         end
      end
      valid_in = 1'b0;
      for (int w = 0; w < 20 && done_cnt == 0; w++) step();
      chk($sformatf("job%0d_done_cnt", j), done_cnt, 1);
      chk($sformatf("job%0d_out_cnt", j), out_dat.size(), jb.pix);
      for (int k = 0; k < jb.pix && k < out_dat.size(); k++) begin
         chk($sformatf("job%0d_b%0d_lane0", j, k), s16(out_dat[k][15:0]), s16(jb.e0[k]));
         chk($sformatf("job%0d_b%0d_lane1", j, k), s16(out_dat[k][31:16]), s16(jb.e1[k]));
         chk($sformatf("job%0d_b%0d_latency", j, k), out_cyc[k] - in_last[k], 2);
      end
      if (out_cyc.size() > 0)
         chk($sformatf("job%0d_done_with_last", j), done_cyc, out_cyc[out_cyc.size()-1]);
      chk($sformatf("job%0d_ram_writes", j), we_cnt, jb.pix * (jb.pas - 1));
      step();
      chk($sformatf("job%0d_busy_fall", j), int'(busy), 0);
   endtask

   initial begin
      int e_base;
      jobs[0] = '{4, 3, 1'b0, q4(1, 2, 3, 4), q4(1, 2, 3, 4), q4(3, 6, 9, 12), q4(3, 6, 9, 12)};
      jobs[1] = '{2, 1, 1'b0, q4(7, -5, 0, 0), q4(7, -5, 0, 0), q4(7, -5, 0, 0), q4(7, -5, 0, 0)};
      jobs[2] = '{1, 4, 1'b0, q4(10, 0, 0, 0), q4(10, 0, 0, 0), q4(40, 0, 0, 0), q4(40, 0, 0, 0)};
      jobs[3] = '{1, 4, 1'b1, q4(10, 0, 0, 0), q4(10, 0, 0, 0), q4(40, 0, 0, 0), q4(40, 0, 0, 0)};
      jobs[4] = '{1, 2, 1'b0, q4(30000, 0, 0, 0), q4(-30000, 0, 0, 0), q4(32767, 0, 0, 0), q4(-32768, 0, 0, 0)};
      jobs[5] = '{2, 3, 1'b0, q4(20000, -100, 0, 0), q4(-20000, 5, 0, 0), q4(32767, -300, 0, 0), q4(-32768, 15, 0, 0)};
      jobs[6] = '{3, 2, 1'b1, q4(1, 2, 3, 0), q4(-4, 0, 7, 0), q4(2, 4, 6, 0), q4(-8, 0, 14, 0)};
      jobs[7] = '{2, 2, 1'b0, q4(1, 1, 0, 0), q4(1, 1, 0, 0), q4(2, 2, 0, 0), q4(2, 2, 0, 0)};

      step(); step();
      chk("rst_valid_out", int'(valid_out), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_data_out", int'(data_out), 0);
      rst_n = 1'b1;
      step();

      for (int j = 0; j < 7; j++) run_job(j);

      // illegal starts and idle beats
      out_cyc.delete(); out_dat.delete(); err_cnt = 0;
      for (int e = 0; e < 3; e++) begin
         pixel_num = (e == 0) ? 16'd0 : (e == 1) ? 16'd1025 : 16'd4;
         pass_num  = (e == 2) ? 8'd0 : 8'd2;
         start = 1'b1;
         step();
         start = 1'b0;
         chk($sformatf("bad%0d_err_pulse", e), int'(err), 1);
         chk($sformatf("bad%0d_busy", e), int'(busy), 0);
         step();
         chk($sformatf("bad%0d_err_clear", e), int'(err), 0);
      end
      for (int k = 0; k < 3; k++) begin
         valid_in = 1'b1; data_in = pk(16'd9, 16'd9);
         step();
      end
      valid_in = 1'b0;
      step(); step();
      chk("bad_err_total", err_cnt, 3);
      chk("idle_no_out", out_dat.size(), 0);

      // abort mid pass 1, with a start attempted while busy
      out_cyc.delete(); out_dat.delete(); done_cnt = 0; e_base = err_cnt;
      pixel_num = 16'd2; pass_num = 8'd3; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         valid_in = 1'b1; data_in = pk(16'd5, 16'd5);
         if (k == 1) begin start = 1'b1; pixel_num = 16'd0; end
         step();
         start = 1'b0;
      end
      valid_in = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("abort_valid_out", int'(valid_out), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_data_out", int'(data_out), 0);
      step(); step();
      chk("abort_no_done", done_cnt, 0);
      chk("abort_no_out", out_dat.size(), 0);
      chk("busy_start_no_err", err_cnt, e_base);
      rst_n = 1'b1;
      step();
      run_job(7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
